crossbar_line_param: RTL

CROSSBAR_LINE_PARAM -- requirements
Module: crossbar_line_param

---
 rtl/crossbar_line_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crossbar_line_param.sv
// Single-input line crossbar: buffers an AXI-Stream input in a FIFO and forwards
// each packet, cut-through, to the output port named by its first beat's tdest.
module crossbar_line_param #(
  parameter int P_CROSSBAR_N = 4,
  parameter int P_DATA_W     = 64,
  parameter int P_DEST_W     = 3,
  parameter int P_FIFO_DEPTH = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic [P_CROSSBAR_N-1:0]        o_trans_req,
  input  logic [P_CROSSBAR_N-1:0]        i_trans_grant,
  input  logic                           s_axis_rx_tvalid,
  input  logic [P_DATA_W-1:0]            s_axis_rx_tdata,
  input  logic                           s_axis_rx_tlast,
  input  logic [P_DATA_W/8-1:0]          s_axis_rx_tkeep,
  input  logic                           s_axis_rx_tuser,
  input  logic [P_DEST_W-1:0]            s_axis_rx_tdest,
  output logic                           s_axis_rx_tready,
  output logic [P_CROSSBAR_N-1:0]        m_axis_tx_tvalid,
  output logic [P_CROSSBAR_N*P_DATA_W-1:0]     m_axis_tx_tdata,
  output logic [P_CROSSBAR_N-1:0]        m_axis_tx_tlast,
  output logic [P_CROSSBAR_N*P_DATA_W/8-1:0]   m_axis_tx_tkeep,
  output logic [P_CROSSBAR_N-1:0]        m_axis_tx_tuser,
  input  logic [P_CROSSBAR_N-1:0]        m_axis_tx_tready,
  output logic [15:0]                    o_drop_cnt
);
  localparam int KW = P_DATA_W / 8;
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = P_DEST_W + 2 + KW + P_DATA_W;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WW-1:0]       mem_q [P_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  state_t              state_q, state_d;
  logic [P_DEST_W-1:0] cur_dest_q, cur_dest_d;
  logic [15:0]         drop_q, drop_d;

  logic                    push, pop, empty;
  logic [WW-1:0]           head;
  logic [P_DATA_W-1:0]     head_data;
  logic [KW-1:0]           head_keep;
  logic                    head_last, head_user;
  logic [P_DEST_W-1:0]     head_dest;
  logic [P_CROSSBAR_N-1:0] sel, tx_vld;

  assign head      = mem_q[rd_ptr_q];
  assign head_data = head[P_DATA_W-1:0];
  assign head_keep = head[P_DATA_W +: KW];
  assign head_last = head[P_DATA_W+KW];
  assign head_user = head[P_DATA_W+KW+1];
  assign head_dest = head[P_DATA_W+KW+2 +: P_DEST_W];

  // Ready is forced low while reset is held, even though the count is already zero.
  assign s_axis_rx_tready = i_rst & (count_q < CW'(P_FIFO_DEPTH));
  assign push  = s_axis_rx_tvalid & s_axis_rx_tready;
  assign empty = (count_q == '0);

  always_comb begin
    sel = '0;
    for (int k = 0; k < P_CROSSBAR_N; k++) sel[k] = (cur_dest_q == P_DEST_W'(k));
  end

  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    drop_d     = drop_q;
    pop        = 1'b0;
    o_trans_req = '0;
    tx_vld     = '0;
    unique case (state_q)
      IDLE: if (!empty) begin
        cur_dest_d = head_dest;
        // Widened compare so N == 2^P_DEST_W does not wrap to zero.
        state_d = ({1'b0, head_dest} < (P_DEST_W+1)'(P_CROSSBAR_N)) ? REQ : DROP;
      end
      REQ: begin
        o_trans_req = sel;
        if (|(i_trans_grant & sel)) state_d = XFER;
      end
      XFER: begin
        o_trans_req = sel;
        tx_vld = sel & i_trans_grant & {P_CROSSBAR_N{!empty}};
        pop    = |(tx_vld & m_axis_tx_tready);
        if (pop && head_last) state_d = IDLE;
      end
      DROP: begin
        pop = !empty;
        if (pop && head_last) begin
          drop_d  = sat_inc(drop_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    m_axis_tx_tdata = '0;
    m_axis_tx_tkeep = '0;
    m_axis_tx_tlast = '0;
    m_axis_tx_tuser = '0;
    for (int k = 0; k < P_CROSSBAR_N; k++) begin
      if (tx_vld[k]) begin
        m_axis_tx_tdata[k*P_DATA_W +: P_DATA_W] = head_data;
        m_axis_tx_tkeep[k*KW +: KW]             = head_keep;
        m_axis_tx_tlast[k]                      = head_last;
        m_axis_tx_tuser[k]                      = head_user;
      end
    end
  end

  assign m_axis_tx_tvalid = tx_vld;
  assign o_drop_cnt       = drop_q;

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_rx_tdest, s_axis_rx_tuser, s_axis_rx_tlast,
                                  s_axis_rx_tkeep, s_axis_rx_tdata};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      cur_dest_q <= '0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      drop_q     <= drop_d;
    end
  end
endmodule
